wdg_multistage: RTL and testbench

WDG_MULTISTAGE -- requirements
Module: wdg_multistage

---
 rtl/wdg_multistage.sv | 193 +++++++++++++++++++
 tb/tb_wdg_multistage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wdg_multistage.sv
// wdg_multistage: multi-stage escalating watchdog timer.
//
// A CNT_W-bit down-counter is loaded from 'reload' whenever the watchdog is
// started or serviced. Each time it reaches zero, the current stage expires:
// its sticky flag in stage_wto is set, wto_pulse fires for one cycle and the
// next stage is loaded. After the last stage expires the block parks in HOLD
// until it is serviced with a kick or disabled with en=0.
//
// Optional feature: define WDG_WINDOW_EN to enable window mode. That adds the
// 'win' input and the sticky 'early_err' output. In window mode, a kick that
// arrives in stage 0 while the counter is still above 'win' counts as a
// premature service: every stage flag is raised at once and the block goes to
// HOLD. Further kicks are then ignored until en=0 or res.
//
// All outputs come straight from flops. Next-state logic is computed in one
// combinational block and registered in one sequential block.

module wdg_multistage #(
   parameter int CNT_W  = 16,
   parameter int NSTAGE = 2
) (
   input  logic              clk,
   input  logic              res,
   input  logic              en,
   input  logic [CNT_W-1:0]  reload,
   input  logic              kick,
`ifdef WDG_WINDOW_EN
   input  logic [CNT_W-1:0]  win,
   output logic              early_err,
`endif
   output logic [NSTAGE-1:0] stage_wto,
   output logic              wto_pulse,
   output logic [CNT_W-1:0]  cnt,
   output logic              active
);

   // Width of the stage index. NSTAGE is at least 2, so this is at least 1.
   localparam int SW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_COUNT = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   localparam logic [SW-1:0] LAST_STAGE = SW'(NSTAGE - 1);

   // Registered state.
   logic [1:0]        r_state;
   logic [SW-1:0]     r_stage;
   logic [CNT_W-1:0]  r_cnt;
   logic [NSTAGE-1:0] r_wto;
   logic              r_pulse;
   logic              r_active;

   // Next-state values.
   logic [1:0]        w_state;
   logic [SW-1:0]     w_stage;
   logic [CNT_W-1:0]  w_cnt;
   logic [NSTAGE-1:0] w_wto;
   logic              w_pulse;
   logic              w_active;

   logic              w_cntZero;
   logic              w_kickOk;
   logic              w_earlyKick;

`ifdef WDG_WINDOW_EN
   logic              r_early;
   logic              w_early;
`endif

   assign w_cntZero = (r_cnt == '0);

`ifdef WDG_WINDOW_EN
   // Once a premature service has been flagged, kicks are ignored. A kick is
   // premature only in stage 0 of COUNT while the counter is still above win.
   always_comb begin
      w_kickOk    = kick & ~r_early;
      w_earlyKick = w_kickOk & (r_state == ST_COUNT) & (r_stage == '0) & (r_cnt > win);
   end
`else
   // Without window mode, every kick is a valid service.
   always_comb begin
      w_kickOk    = kick;
      w_earlyKick = 1'b0;
   end
`endif

   // Next-state logic. Precedence, highest first: disable, kick, stage
   // expiry, then decrement. Reset is handled in the sequential block.
   always_comb begin
      w_state  = r_state;
      w_stage  = r_stage;
      w_cnt    = r_cnt;
      w_wto    = r_wto;
      w_pulse  = 1'b0;
`ifdef WDG_WINDOW_EN
      w_early  = r_early;
`endif

      if (!en) begin
         w_state = ST_IDLE;
         w_stage = '0;
         w_cnt   = '0;
         w_wto   = '0;
`ifdef WDG_WINDOW_EN
         w_early = 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state = ST_COUNT;
               w_stage = '0;
               w_cnt   = reload;
               w_wto   = '0;
            end

            ST_COUNT, ST_HOLD: begin
               if (w_earlyKick) begin
                  w_state = ST_HOLD;
                  w_cnt   = '0;
                  w_wto   = '1;
                  w_pulse = 1'b1;
`ifdef WDG_WINDOW_EN
                  w_early = 1'b1;
`endif
               end else if (w_kickOk) begin
                  w_state = ST_COUNT;
                  w_stage = '0;
                  w_cnt   = reload;
                  w_wto   = '0;
               end else if (r_state == ST_COUNT) begin
                  if (w_cntZero) begin
                     w_wto[r_stage] = 1'b1;
                     w_pulse        = 1'b1;
                     if (r_stage == LAST_STAGE) begin
                        w_state = ST_HOLD;
                        w_cnt   = '0;
                     end else begin
                        w_stage = r_stage + SW'(1);
                        w_cnt   = reload;
                     end
                  end else begin
                     w_cnt = r_cnt - CNT_W'(1);
                  end
               end
            end

            default: begin
               w_state = ST_IDLE;
               w_stage = '0;
               w_cnt   = '0;
               w_wto   = '0;
            end
         endcase
      end

      w_active = (w_state != ST_IDLE);
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (res) begin
         r_state  <= ST_IDLE;
         r_stage  <= '0;
         r_cnt    <= '0;
         r_wto    <= '0;
         r_pulse  <= 1'b0;
         r_active <= 1'b0;
`ifdef WDG_WINDOW_EN
         r_early  <= 1'b0;
`endif
      end else begin
         r_state  <= w_state;
         r_stage  <= w_stage;
         r_cnt    <= w_cnt;
         r_wto    <= w_wto;
         r_pulse  <= w_pulse;
         r_active <= w_active;
`ifdef WDG_WINDOW_EN
         r_early  <= w_early;
`endif
      end
   end

   assign stage_wto = r_wto;
   assign wto_pulse = r_pulse;
   assign cnt       = r_cnt;
   assign active    = r_active;
`ifdef WDG_WINDOW_EN
   assign early_err = r_early;
`endif

endmodule

// File: tb/tb_wdg_multistage.sv
// tb_wdg_multistage: directed self-checking bench for wdg_multistage with
// CNT_W=8, NSTAGE=3 and reload=5 unless a test says otherwise. The window
// mode tests are compiled in only when WDG_WINDOW_EN is defined.

module tb_wdg_multistage;

   logic       clk;
   logic       res;
   logic       en;
   logic [7:0] reload;
   logic       kick;
   logic [2:0] stage_wto;
   logic       wto_pulse;
   logic [7:0] cnt;
   logic       active;
`ifdef WDG_WINDOW_EN
   logic [7:0] win;
   logic       early_err;
`endif

   int         nCompared;
   int         nMismatched;
   int         p;
   logic [7:0] expCnt;
   logic [2:0] expWto;
   logic       expPulse;

   wdg_multistage #(.CNT_W(8), .NSTAGE(3)) dut (
      .clk       (clk),
      .res       (res),
      .en        (en),
      .reload    (reload),
      .kick      (kick),
`ifdef WDG_WINDOW_EN
      .win       (win),
      .early_err (early_err),
`endif
      .stage_wto (stage_wto),
      .wto_pulse (wto_pulse),
      .cnt       (cnt),
      .active    (active)
   );

   // 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Return to IDLE, then raise en so the last edge is t0 (cnt = reload).
   task automatic restart();
      en   = 1'b0;
      kick = 1'b0;
      tick();
      en = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      res    = 1'b1;
      en     = 1'b1;
      kick   = 1'b0;
      reload = 8'd5;
      tick();
      tick();
      if (cnt !== 8'd0) begin nMismatched++; $display("[TB] FAIL reset_cnt got %0d exp 0", cnt); end
      nCompared++;
      if (stage_wto !== 3'b000) begin nMismatched++; $display("[TB] FAIL reset_wto got %b exp 000", stage_wto); end
      nCompared++;
      if (wto_pulse !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_pulse got %b exp 0", wto_pulse); end
      nCompared++;
      if (active !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_active got %b exp 0", active); end
      nCompared++;
      res = 1'b0;
      en  = 1'b0;
      tick();
      if (active !== 1'b0) begin nMismatched++; $display("[TB] FAIL idle_active got %b exp 0", active); end
      nCompared++;
   endtask

   // Full escalation with no service: expiries at t0+6, t0+12, t0+18.
   task automatic test_escalation();
      reload = 8'd5;
      restart();
      if (cnt !== 8'd5) begin nMismatched++; $display("[TB] FAIL esc_load_cnt got %0d exp 5", cnt); end
      nCompared++;
      if (active !== 1'b1) begin nMismatched++; $display("[TB] FAIL esc_active got %b exp 1", active); end
      nCompared++;
      for (int k = 1; k <= 21; k++) begin
         tick();
         p        = k % 6;
         expCnt   = (k >= 18) ? 8'd0 : ((p == 0) ? 8'd5 : 8'(5 - p));
         expWto   = (k >= 18) ? 3'b111 : (k >= 12) ? 3'b011 : (k >= 6) ? 3'b001 : 3'b000;
         expPulse = (k == 6) || (k == 12) || (k == 18);
         if (cnt !== expCnt) begin nMismatched++; $display("[TB] FAIL esc_cnt t0+%0d got %0d exp %0d", k, cnt, expCnt); end
         nCompared++;
         if (stage_wto !== expWto) begin nMismatched++; $display("[TB] FAIL esc_wto t0+%0d got %b exp %b", k, stage_wto, expWto); end
         nCompared++;
         if (wto_pulse !== expPulse) begin nMismatched++; $display("[TB] FAIL esc_pulse t0+%0d got %b exp %b", k, wto_pulse, expPulse); end
         nCompared++;
      end
      if (active !== 1'b1) begin nMismatched++; $display("[TB] FAIL hold_active got %b exp 1", active); end
      nCompared++;
   endtask

   // Leaving HOLD by kick, then by disable.
   task automatic test_hold_exit();
      kick = 1'b1;
      tick();
      kick = 1'b0;
      if (stage_wto !== 3'b000) begin nMismatched++; $display("[TB] FAIL hold_kick_wto got %b exp 000", stage_wto); end
      nCompared++;
      if (cnt !== 8'd5) begin nMismatched++; $display("[TB] FAIL hold_kick_cnt got %0d exp 5", cnt); end
      nCompared++;
      if (active !== 1'b1) begin nMismatched++; $display("[TB] FAIL hold_kick_active got %b exp 1", active); end
      nCompared++;
      for (int k = 1; k <= 18; k++) tick();
      if (stage_wto !== 3'b111) begin nMismatched++; $display("[TB] FAIL rehold_wto got %b exp 111", stage_wto); end
      nCompared++;
      en = 1'b0;
      tick();
      if (cnt !== 8'd0) begin nMismatched++; $display("[TB] FAIL dis_cnt got %0d exp 0", cnt); end
      nCompared++;
      if (stage_wto !== 3'b000) begin nMismatched++; $display("[TB] FAIL dis_wto got %b exp 000", stage_wto); end
      nCompared++;
      if (active !== 1'b0) begin nMismatched++; $display("[TB] FAIL dis_active got %b exp 0", active); end
      nCompared++;
   endtask

   // A kick at t0+3 reloads the counter and pushes the first expiry to t0+9.
   task automatic test_kick_service();
      restart();
      tick();
      tick();
      kick = 1'b1;
      tick();
      kick = 1'b0;
      if (cnt !== 8'd5) begin nMismatched++; $display("[TB] FAIL svc_cnt got %0d exp 5", cnt); end
      nCompared++;
      for (int k = 4; k <= 9; k++) begin
         tick();
         expWto   = (k == 9) ? 3'b001 : 3'b000;
         expPulse = (k == 9);
         if (stage_wto !== expWto) begin nMismatched++; $display("[TB] FAIL svc_wto t0+%0d got %b exp %b", k, stage_wto, expWto); end
         nCompared++;
         if (wto_pulse !== expPulse) begin nMismatched++; $display("[TB] FAIL svc_pulse t0+%0d got %b exp %b", k, wto_pulse, expPulse); end
         nCompared++;
      end
   endtask

   // Kick on the edge where cnt==0 in stage 1 wins over expiry; then reset
   // mid-count discards the count.
   task automatic test_kick_at_zero();
      restart();
      for (int k = 1; k <= 11; k++) tick();
      if (cnt !== 8'd0) begin nMismatched++; $display("[TB] FAIL kz_pre_cnt got %0d exp 0", cnt); end
      nCompared++;
      kick = 1'b1;
      tick();
      kick = 1'b0;
      if (stage_wto !== 3'b000) begin nMismatched++; $display("[TB] FAIL kz_wto got %b exp 000", stage_wto); end
      nCompared++;
      if (wto_pulse !== 1'b0) begin nMismatched++; $display("[TB] FAIL kz_pulse got %b exp 0", wto_pulse); end
      nCompared++;
      if (cnt !== 8'd5) begin nMismatched++; $display("[TB] FAIL kz_cnt got %0d exp 5", cnt); end
      nCompared++;
      for (int k = 1; k <= 6; k++) tick();
      if (stage_wto !== 3'b001) begin nMismatched++; $display("[TB] FAIL kz_stage0_wto got %b exp 001", stage_wto); end
      nCompared++;
      tick();
      tick();
      res = 1'b1;
      tick();
      res = 1'b0;
      if ({stage_wto, wto_pulse, cnt, active} !== 13'd0) begin
         nMismatched++;
         $display("[TB] FAIL midreset got wto=%b pulse=%b cnt=%0d active=%b exp all 0", stage_wto, wto_pulse, cnt, active);
      end
      nCompared++;
      tick();
      if (cnt !== 8'd5) begin nMismatched++; $display("[TB] FAIL postreset_cnt got %0d exp 5", cnt); end
      nCompared++;
   endtask

   // reload=0 gives one-cycle stages; reload is only sampled at loads.
   task automatic test_reload_zero();
      reload = 8'd0;
      restart();
      for (int k = 1; k <= 4; k++) begin
         tick();
         expWto   = (k == 1) ? 3'b001 : (k == 2) ? 3'b011 : 3'b111;
         expPulse = (k <= 3);
         if (stage_wto !== expWto) begin nMismatched++; $display("[TB] FAIL r0_wto t0+%0d got %b exp %b", k, stage_wto, expWto); end
         nCompared++;
         if (wto_pulse !== expPulse) begin nMismatched++; $display("[TB] FAIL r0_pulse t0+%0d got %b exp %b", k, wto_pulse, expPulse); end
         nCompared++;
         if (cnt !== 8'd0) begin nMismatched++; $display("[TB] FAIL r0_cnt t0+%0d got %0d exp 0", k, cnt); end
         nCompared++;
      end
      reload = 8'd5;
      restart();
      reload = 8'd2;
      tick();
      if (cnt !== 8'd4) begin nMismatched++; $display("[TB] FAIL rl_nosample got %0d exp 4", cnt); end
      nCompared++;
      reload = 8'd5;
   endtask

   // Kick in IDLE is ignored; quick en toggles in and out of COUNT.
   task automatic test_back_to_back();
      en   = 1'b0;
      tick();
      kick = 1'b1;
      tick();
      kick = 1'b0;
      if (active !== 1'b0) begin nMismatched++; $display("[TB] FAIL idle_kick_active got %b exp 0", active); end
      nCompared++;
      if (cnt !== 8'd0) begin nMismatched++; $display("[TB] FAIL idle_kick_cnt got %0d exp 0", cnt); end
      nCompared++;
      en = 1'b1;
      tick();
      en = 1'b0;
      tick();
      en = 1'b1;
      tick();
      if (cnt !== 8'd5) begin nMismatched++; $display("[TB] FAIL b2b_cnt got %0d exp 5", cnt); end
      nCompared++;
      if (active !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_active got %b exp 1", active); end
      nCompared++;
   endtask

`ifdef WDG_WINDOW_EN
   // Early kick at cnt=4 with win=2, then an accepted kick at cnt=2.
   task automatic test_window();
      win = 8'd2;
      restart();
      tick();
      kick = 1'b1;
      tick();
      kick = 1'b0;
      if (early_err !== 1'b1) begin nMismatched++; $display("[TB] FAIL win_early got %b exp 1", early_err); end
      nCompared++;
      if (stage_wto !== 3'b111) begin nMismatched++; $display("[TB] FAIL win_wto got %b exp 111", stage_wto); end
      nCompared++;
      if (wto_pulse !== 1'b1) begin nMismatched++; $display("[TB] FAIL win_pulse got %b exp 1", wto_pulse); end
      nCompared++;
      kick = 1'b1;
      tick();
      kick = 1'b0;
      if (stage_wto !== 3'b111 || cnt !== 8'd0 || early_err !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL win_ignore got wto=%b cnt=%0d early=%b exp 111/0/1", stage_wto, cnt, early_err);
      end
      nCompared++;
      restart();
      if (early_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL win_clear got %b exp 0", early_err); end
      nCompared++;
      tick();
      tick();
      tick();
      kick = 1'b1;
      tick();
      kick = 1'b0;
      if (cnt !== 8'd5 || early_err !== 1'b0 || stage_wto !== 3'b000) begin
         nMismatched++;
         $display("[TB] FAIL win_ok got cnt=%0d early=%b wto=%b exp 5/0/000", cnt, early_err, stage_wto);
      end
      nCompared++;
      win = 8'hFF;
   endtask
`endif

   // Run every scenario in order, then print the summary.
   initial begin
      nCompared   = 0;
      nMismatched = 0;
      res         = 1'b1;
      en          = 1'b0;
      kick        = 1'b0;
      reload      = 8'd5;
`ifdef WDG_WINDOW_EN
      win         = 8'hFF;
`endif
      test_reset();
      test_escalation();
      test_hold_exit();
      test_kick_service();
      test_kick_at_zero();
      test_reload_zero();
      test_back_to_back();
`ifdef WDG_WINDOW_EN
      test_window();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
